// File: rtl/stream_checker_pkg.sv
// stream_pkg: shared definitions for the stream checker slice.
//   - state_t      : checker FSM states (IDLE, SYNC, CHECK)
//   - LFSR_SEED    : reset/clear seed of the optional random-stall LFSR
//   - LFSR_TAPS    : Galois tap mask for x^8+x^6+x^5+x^4+1 (right-shifting form)
//   - DEF_*        : default widths for data, beat counter and error counter
//   - lfsr_next()  : one step of the Galois LFSR
package stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Right-shift Galois form: taps at x^8, x^6, x^5 and x^4 map to bits 7, 5, 4 and 3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_BEAT_W = 16;
  localparam int DEF_ERR_W  = 8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/stream_checker_if.sv
// stream_checker_if: 8-bit (WIDTH) ready/valid stream bundle.
//   valid : beat valid, driven by the source
//   data  : beat payload, driven by the source
//   ready : sink can accept; a beat transfers on a rising edge where
//           valid & ready are both high. The source must hold valid/data
//           stable until the transfer; ready never depends on valid.
// Modports: master = stream source, slave = stream sink.
interface stream_checker_if #(
  parameter int WIDTH = 8
) ();
  logic             valid;
  logic [WIDTH-1:0] data;
  logic             ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/stream_checker_stall_gen.sv
// stall_gen: post-accept backpressure counter for the stream checker.
//   clk, rst    : clock, asynchronous active-high reset
//   clear       : synchronous clear; zeroes the counter (and reseeds the LFSR)
//   accept      : a beat was accepted on this edge; loads the counter
//   stall       : idle cycles to insert after each accept
//   rand_stall  : (STREAM_CHECKER_LFSR_EN only) load LFSR[3:0] instead of stall
//   stall_done  : counter is zero, the checker may accept again
// Optional feature macro: STREAM_CHECKER_LFSR_EN adds an 8-bit Galois LFSR
// that advances every clock and can supply random stall lengths.
module stall_gen
  import stream_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       accept,
  input  logic [3:0] stall,
`ifdef STREAM_CHECKER_LFSR_EN
  input  logic       rand_stall,
`endif
  output logic       stall_done
);

  logic [3:0] cnt_q, cnt_d;
  logic [3:0] load_val;

`ifdef STREAM_CHECKER_LFSR_EN
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = clear ? LFSR_SEED : lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  // The current (pre-advance) LFSR value is what gets loaded.
  assign load_val = rand_stall ? lfsr_q[3:0] : stall;
`else
  assign load_val = stall;
`endif

  // clear beats a coincident accept so the counter restarts at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)               cnt_d = 4'd0;
    else if (accept)         cnt_d = load_val;
    else if (cnt_q != 4'd0)  cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 4'd0;
    else     cnt_q <= cnt_d;
  end

  assign stall_done = (cnt_q == 4'd0);

endmodule

// File: rtl/stream_checker.sv
// stream_checker: consumer for an incrementing 8-bit ready/valid stream.
// Accepts beats under programmable backpressure and checks each beat equals
// the previous beat + 1 (mod 2^WIDTH). Counts beats and mismatches and
// captures the first mismatch.
//   clk, rst    : clock, asynchronous active-high reset
//   enable      : low forces ready low and returns the FSM to IDLE
//   clear       : synchronous clear of counters, flags, captures
//   stall       : idle cycles after each accept (0 = full rate)
//   rand_stall  : (STREAM_CHECKER_LFSR_EN only) use LFSR stall lengths
//   s_if        : stream sink (valid/data in, ready out)
//   locked      : expected value seeded (FSM in CHECK)
//   beat_count  : accepted beats, wrapping
//   err_count   : mismatches, saturating
//   err_flag    : sticky first-mismatch flag
//   first_exp   : expected value at first mismatch
//   first_got   : received value at first mismatch
//   dbg_state   : FSM state for debug/observation
// Optional feature macro: STREAM_CHECKER_LFSR_EN (random stall lengths).
module stream_checker
  import stream_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int BEAT_W = DEF_BEAT_W,
  parameter int ERR_W  = DEF_ERR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clear,
  input  logic [3:0]        stall,
`ifdef STREAM_CHECKER_LFSR_EN
  input  logic              rand_stall,
`endif
  stream_checker_if.slave   s_if,
  output logic              locked,
  output logic [BEAT_W-1:0] beat_count,
  output logic [ERR_W-1:0]  err_count,
  output logic              err_flag,
  output logic [WIDTH-1:0]  first_exp,
  output logic [WIDTH-1:0]  first_got,
  output state_t            dbg_state
);

  state_t            state_q;
  logic [WIDTH-1:0]  exp_q;
  logic [WIDTH-1:0]  exp_d;
  logic [BEAT_W-1:0] beat_q;
  logic [ERR_W-1:0]  err_q;
  logic              flag_q;
  logic [WIDTH-1:0]  fexp_q;
  logic [WIDTH-1:0]  fgot_q;
  logic              stall_done;
  logic              ready;
  logic              accept;
  logic              mismatch;

  // ready comes only from registered state and enable, never from valid.
  assign ready    = enable & (state_q != IDLE) & stall_done;
  assign accept   = s_if.valid & ready;
  assign exp_d    = s_if.data + WIDTH'(1);
  assign mismatch = (s_if.data != exp_q);

  stall_gen u_stall_gen (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .accept     (accept),
    .stall      (stall),
`ifdef STREAM_CHECKER_LFSR_EN
    .rand_stall (rand_stall),
`endif
    .stall_done (stall_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      exp_q   <= '0;
      beat_q  <= '0;
      err_q   <= '0;
      flag_q  <= 1'b0;
      fexp_q  <= '0;
      fgot_q  <= '0;
    end else if (clear) begin
      // A beat accepted on this edge is consumed but deliberately not counted.
      state_q <= enable ? SYNC : IDLE;
      exp_q   <= '0;
      beat_q  <= '0;
      err_q   <= '0;
      flag_q  <= 1'b0;
      fexp_q  <= '0;
      fgot_q  <= '0;
    end else if (!enable) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: state_q <= SYNC;
        SYNC: begin
          if (accept) begin
            state_q <= CHECK;
            exp_q   <= exp_d;
            beat_q  <= beat_q + BEAT_W'(1);
          end
        end
        CHECK: begin
          if (accept) begin
            // Always resync to the received beat: one bad beat costs one error.
            exp_q  <= exp_d;
            beat_q <= beat_q + BEAT_W'(1);
            if (mismatch) begin
              if (err_q != {ERR_W{1'b1}}) err_q <= err_q + ERR_W'(1);
              if (!flag_q) begin
                flag_q <= 1'b1;
                fexp_q <= exp_q;
                fgot_q <= s_if.data;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_if.ready = ready;
  assign locked     = (state_q == CHECK);
  assign beat_count = beat_q;
  assign err_count  = err_q;
  assign err_flag   = flag_q;
  assign first_exp  = fexp_q;
  assign first_got  = fgot_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_stream_checker.sv
module tb_stream_checker;
  import stream_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  stall = 4'd0;
`ifdef STREAM_CHECKER_LFSR_EN
  logic        rand_stall = 1'b0;
`endif
  logic        locked;
  logic [15:0] beat_count;
  logic [7:0]  err_count;
  logic        err_flag;
  logic [7:0]  first_exp;
  logic [7:0]  first_got;
  state_t      dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  stream_checker_if #(.WIDTH(8)) s_if ();

  stream_checker dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .clear      (clear),
    .stall      (stall),
`ifdef STREAM_CHECKER_LFSR_EN
    .rand_stall (rand_stall),
`endif
    .s_if       (s_if.slave),
    .locked     (locked),
    .beat_count (beat_count),
    .err_count  (err_count),
    .err_flag   (err_flag),
    .first_exp  (first_exp),
    .first_got  (first_got),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    s_if.valid = 1'b0;
    s_if.data  = 8'd0;
  end

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    s_if.valid = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Drive one beat and hold it until the checker takes it (bounded wait).
  task automatic send(input logic [7:0] d);
    int n;
    s_if.valid = 1'b1;
    s_if.data  = d;
    n = 0;
    while (!s_if.ready && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: ready never rose for beat %0d (waited %0d cycles, required < 100)", d, n);
    end
    step();
    s_if.valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++; if (s_if.ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", s_if.ready); end
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked: got %b want 0", locked); end
    n_cmp++; if (beat_count !== 16'd0) begin n_err++; $display("FAIL reset_beats: got %0d want 0", beat_count); end
    n_cmp++; if (err_count !== 8'd0 || err_flag !== 1'b0) begin n_err++; $display("FAIL reset_err: got cnt %0d flag %b want 0/0", err_count, err_flag); end
    n_cmp++; if (first_exp !== 8'd0 || first_got !== 8'd0) begin n_err++; $display("FAIL reset_capture: got %0d/%0d want 0/0", first_exp, first_got); end
    rst = 1'b0;
  endtask

  task automatic test_full_rate();
    int low;
    enable = 1'b1;
    stall  = 4'd0;
    n_cmp++; if (s_if.ready !== 1'b0) begin n_err++; $display("FAIL idle_ready: got %b want 0", s_if.ready); end
    step();
    low = 0;
    for (int i = 0; i < 300; i++) begin
      s_if.valid = 1'b1;
      s_if.data  = 8'(i);
      if (s_if.ready !== 1'b1) low++;
      step();
    end
    s_if.valid = 1'b0;
    n_cmp++; if (low != 0) begin n_err++; $display("FAIL full_rate_ready: ready low in %0d cycles want 0", low); end
    n_cmp++; if (beat_count !== 16'd300) begin n_err++; $display("FAIL full_rate_beats: got %0d want 300", beat_count); end
    n_cmp++; if (err_count !== 8'd0 || err_flag !== 1'b0) begin n_err++; $display("FAIL full_rate_err: got cnt %0d flag %b want 0/0", err_count, err_flag); end
    n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL full_rate_locked: got %b want 1", locked); end
  endtask

  task automatic test_stall();
    logic [15:0] pat;
    logic [7:0]  d;
    do_clear();
    n_cmp++; if (beat_count !== 16'd0 || locked !== 1'b0) begin n_err++; $display("FAIL clear_state: got beats %0d locked %b want 0/0", beat_count, locked); end
    stall = 4'd3;
    d = 8'd100;
    pat = 16'h0;
    for (int c = 0; c < 16; c++) begin
      s_if.valid = 1'b1;
      s_if.data  = d;
      pat[c] = s_if.ready;
      step();
      if (pat[c]) d = d + 8'd1;
    end
    s_if.valid = 1'b0;
    n_cmp++; if (pat !== 16'h1111) begin n_err++; $display("FAIL stall3_pattern: got %h want 1111", pat); end
    n_cmp++; if (beat_count !== 16'd4) begin n_err++; $display("FAIL stall3_beats: got %0d want 4", beat_count); end
    n_cmp++; if (err_count !== 8'd0) begin n_err++; $display("FAIL stall3_err: got %0d want 0", err_count); end
    stall = 4'd0;
    for (int c = 0; c < 4; c++) step();
  endtask

  task automatic test_mismatch();
    logic [7:0] seq [5];
    seq = '{8'd10, 8'd11, 8'd12, 8'd20, 8'd21};
    do_clear();
    for (int i = 0; i < 5; i++) send(seq[i]);
    n_cmp++; if (err_count !== 8'd1) begin n_err++; $display("FAIL mismatch_count: got %0d want 1", err_count); end
    n_cmp++; if (err_flag !== 1'b1) begin n_err++; $display("FAIL mismatch_flag: got %b want 1", err_flag); end
    n_cmp++; if (first_exp !== 8'd13 || first_got !== 8'd20) begin n_err++; $display("FAIL mismatch_capture: got exp %0d got %0d want 13/20", first_exp, first_got); end
    n_cmp++; if (beat_count !== 16'd5) begin n_err++; $display("FAIL mismatch_beats: got %0d want 5", beat_count); end
  endtask

  // Constant data 0 after expected=22: every beat mismatches.
  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      s_if.valid = 1'b1;
      s_if.data  = 8'd0;
      step();
    end
    s_if.valid = 1'b0;
    n_cmp++; if (err_count !== 8'd255) begin n_err++; $display("FAIL saturate_count: got %0d want 255", err_count); end
    n_cmp++; if (first_exp !== 8'd13 || first_got !== 8'd20) begin n_err++; $display("FAIL saturate_capture: got exp %0d got %0d want 13/20", first_exp, first_got); end
    n_cmp++; if (beat_count !== 16'd305) begin n_err++; $display("FAIL saturate_beats: got %0d want 305", beat_count); end
  endtask

  task automatic test_clear_accept();
    s_if.valid = 1'b1;
    s_if.data  = 8'd99;
    clear = 1'b1;
    n_cmp++; if (s_if.ready !== 1'b1) begin n_err++; $display("FAIL clear_acc_ready: got %b want 1", s_if.ready); end
    step();
    clear = 1'b0;
    s_if.valid = 1'b0;
    n_cmp++; if (beat_count !== 16'd0 || err_count !== 8'd0 || err_flag !== 1'b0) begin n_err++; $display("FAIL clear_acc_counters: got beats %0d err %0d flag %b want 0/0/0", beat_count, err_count, err_flag); end
    n_cmp++; if (first_exp !== 8'd0 || first_got !== 8'd0 || locked !== 1'b0) begin n_err++; $display("FAIL clear_acc_capture: got %0d/%0d locked %b want 0/0/0", first_exp, first_got, locked); end
    send(8'd50);
    send(8'd51);
    n_cmp++; if (beat_count !== 16'd2) begin n_err++; $display("FAIL reseed_beats: got %0d want 2", beat_count); end
    n_cmp++; if (err_count !== 8'd0 || locked !== 1'b1) begin n_err++; $display("FAIL reseed_err: got err %0d locked %b want 0/1", err_count, locked); end
  endtask

  task automatic test_reset_mid();
    stall = 4'd8;
    send(8'd52);
    n_cmp++; if (s_if.ready !== 1'b0) begin n_err++; $display("FAIL stall8_ready: got %b want 0", s_if.ready); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (beat_count !== 16'd0 || locked !== 1'b0 || s_if.ready !== 1'b0) begin n_err++; $display("FAIL async_rst: got beats %0d locked %b ready %b want 0/0/0", beat_count, locked, s_if.ready); end
    stall = 4'd0;
    step();
    rst = 1'b0;
    n_cmp++; if (s_if.ready !== 1'b0) begin n_err++; $display("FAIL post_rst_idle: got ready %b want 0", s_if.ready); end
    step();
    n_cmp++; if (s_if.ready !== 1'b1) begin n_err++; $display("FAIL post_rst_stall_cleared: got ready %b want 1", s_if.ready); end
  endtask

`ifdef STREAM_CHECKER_LFSR_EN
  task automatic test_lfsr_stall();
    logic [7:0] lfsr_m;
    logic [3:0] cnt_m;
    logic       sync_m;
    logic       exp_rdy;
    int         bad;
    int         acc;
    rst = 1'b1;
    step();
    rand_stall = 1'b1;
    enable = 1'b1;
    s_if.valid = 1'b1;
    s_if.data  = 8'd0;
    rst = 1'b0;
    lfsr_m = 8'hA5;
    cnt_m  = 4'd0;
    sync_m = 1'b0;
    bad = 0;
    acc = 0;
    for (int c = 0; c < 60; c++) begin
      exp_rdy = sync_m && (cnt_m == 4'd0);
      if (s_if.ready !== exp_rdy) bad++;
      step();
      if (exp_rdy) begin
        cnt_m = lfsr_m[3:0];
        acc++;
        s_if.data = s_if.data + 8'd1;
      end else if (cnt_m != 4'd0) begin
        cnt_m = cnt_m - 4'd1;
      end
      lfsr_m = lfsr_m[0] ? ((lfsr_m >> 1) ^ 8'hB8) : (lfsr_m >> 1);
      sync_m = 1'b1;
    end
    s_if.valid = 1'b0;
    rand_stall = 1'b0;
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL lfsr_ready_seq: %0d cycles differ from model, want 0", bad); end
    n_cmp++; if (beat_count !== 16'(acc)) begin n_err++; $display("FAIL lfsr_beats: got %0d want %0d", beat_count, acc); end
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_full_rate();
    test_stall();
    test_mismatch();
    test_saturate();
    test_clear_accept();
    test_reset_mid();
`ifdef STREAM_CHECKER_LFSR_EN
    test_lfsr_stall();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time bound in case a wait loop misbehaves.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
